// File: rtl/bar_motion_ctrl.sv
// Frame-synchronous bar position scheduler: applies shadowed config at frame start and steps the bar window.
// Optional build macro BAR_MOTION_PAUSE_EN adds a pause input that freezes motion.
module bar_motion_ctrl #(
  parameter int H_ACTIVE     = 640,
  parameter int W_DEFAULT    = 20,
  parameter int STEP_DEFAULT = 1,
  parameter int FRAME_DIV    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       cfg_valid,
  input  logic [3:0] cfg_step,
  input  logic [5:0] cfg_width,
  input  logic       cfg_bounce,
`ifdef BAR_MOTION_PAUSE_EN
  input  logic       pause,
`endif
  output logic       cfg_ready,
  output logic [9:0] bar_lo,
  output logic [9:0] bar_hi,
  output logic       bar_dir,
  output logic       update_done,
  output logic       overrun
);

  localparam logic [10:0] H_ACT_C    = 11'(H_ACTIVE);
  localparam logic [5:0]  W_DEF_C    = 6'(W_DEFAULT);
  localparam logic [3:0]  STEP_DEF_C = 4'(STEP_DEFAULT);
  localparam logic [3:0]  FDIV_C     = 4'(FRAME_DIV);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_STEP  = 2'd2;

  logic [1:0] state_r;
  logic [9:0] pos_r;
  logic       dir_r;
  logic [3:0] step_r;
  logic [5:0] width_r;
  logic       mode_r;
  logic [3:0] sh_step_r;
  logic [5:0] sh_width_r;
  logic       sh_mode_r;
  logic       pending_r;
  logic       cfg_ready_r;
  logic [3:0] div_r;
  logic       move_en_r;
  logic [9:0] bar_lo_r;
  logic [9:0] bar_hi_r;
  logic       bar_dir_r;
  logic       update_done_r;
  logic       overrun_r;

  logic [3:0]  eff_step_s;
  logic [5:0]  eff_width_s;
  logic        eff_mode_s;
  logic        eff_dir_s;
  logic [9:0]  eff_pos_s;
  logic [10:0] eff_lim_s;
  logic [3:0]  div_inc_s;
  logic        div_hit_s;
  logic        paused_s;
  logic [10:0] motion_s;
  logic [9:0]  new_pos_s;
  logic        new_dir_s;
  logic        xfer_s;

  // Next {dir, pos} for one motion step; all sums are 11 bits so nothing overflows silently.
  function automatic logic [10:0] next_motion(input logic [9:0] pos, input logic dir,
                                              input logic [3:0] step, input logic [5:0] width,
                                              input logic bounce);
    logic [10:0] sum;
    logic [10:0] lim;
    logic [9:0]  p;
    logic        d;
    sum = {1'b0, pos} + {7'd0, step};
    lim = H_ACT_C - {5'd0, width};
    p   = pos;
    d   = dir;
    if (!bounce) begin
      d = 1'b1;
      if (sum >= H_ACT_C) begin
        p = 10'(sum - H_ACT_C);
      end else begin
        p = sum[9:0];
      end
    end else if (dir) begin
      if (sum >= lim) begin
        p = lim[9:0];
        d = 1'b0;
      end else begin
        p = sum[9:0];
        d = 1'b1;
      end
    end else begin
      if ({1'b0, pos} <= {7'd0, step}) begin
        p = 10'd0;
        d = 1'b1;
      end else begin
        p = pos - {6'd0, step};
        d = 1'b0;
      end
    end
    return {d, p};
  endfunction

  // Exclusive end of the bar window, saturated at the right edge of the active line.
  function automatic logic [9:0] bar_end(input logic [9:0] pos, input logic [5:0] width);
    logic [10:0] e;
    e = {1'b0, pos} + {5'd0, width};
    if (e > H_ACT_C) begin
      return H_ACT_C[9:0];
    end else begin
      return e[9:0];
    end
  endfunction

`ifdef BAR_MOTION_PAUSE_EN
  assign paused_s = pause;
`else
  assign paused_s = 1'b0;
`endif

  assign xfer_s = cfg_valid && cfg_ready_r;

  // Settings seen by APPLY (shadow wins when pending) and the STEP motion result.
  always_comb begin
    eff_step_s  = step_r;
    eff_width_s = width_r;
    eff_mode_s  = mode_r;
    eff_dir_s   = dir_r;
    if (pending_r) begin
      eff_step_s  = sh_step_r;
      eff_width_s = sh_width_r;
      eff_mode_s  = sh_mode_r;
      eff_dir_s   = sh_mode_r ? dir_r : 1'b1;
    end else begin
      eff_dir_s   = dir_r;
    end
    eff_lim_s = H_ACT_C - {5'd0, eff_width_s};
    if (eff_mode_s && ({1'b0, pos_r} > eff_lim_s)) begin
      eff_pos_s = eff_lim_s[9:0];
    end else begin
      eff_pos_s = pos_r;
    end
    div_inc_s = div_r + 4'd1;
    div_hit_s = (div_inc_s >= FDIV_C);
    motion_s  = next_motion(pos_r, dir_r, step_r, width_r, mode_r);
    if (move_en_r && !paused_s) begin
      new_pos_s = motion_s[9:0];
      new_dir_s = motion_s[10];
    end else begin
      new_pos_s = pos_r;
      new_dir_s = dir_r;
    end
  end

  // Sequencer, config shadowing and registered bar outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      pos_r         <= 10'd0;
      dir_r         <= 1'b1;
      step_r        <= STEP_DEF_C;
      width_r       <= W_DEF_C;
      mode_r        <= 1'b0;
      sh_step_r     <= STEP_DEF_C;
      sh_width_r    <= W_DEF_C;
      sh_mode_r     <= 1'b0;
      pending_r     <= 1'b0;
      cfg_ready_r   <= 1'b1;
      div_r         <= 4'd0;
      move_en_r     <= 1'b0;
      bar_lo_r      <= 10'd0;
      bar_hi_r      <= 10'(W_DEFAULT);
      bar_dir_r     <= 1'b1;
      update_done_r <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      update_done_r <= 1'b0;
      if (xfer_s) begin
        sh_step_r   <= cfg_step;
        sh_width_r  <= (cfg_width == 6'd0) ? 6'd1 : cfg_width;
        sh_mode_r   <= cfg_bounce;
        pending_r   <= 1'b1;
        cfg_ready_r <= 1'b0;
      end
      if (frame_start && (state_r != S_IDLE)) begin
        overrun_r <= 1'b1;
      end
      case (state_r)
        S_IDLE: begin
          state_r <= frame_start ? S_APPLY : S_IDLE;
        end
        S_APPLY: begin
          if (pending_r) begin
            step_r      <= eff_step_s;
            width_r     <= eff_width_s;
            mode_r      <= eff_mode_s;
            pending_r   <= 1'b0;
            cfg_ready_r <= 1'b1;
          end
          pos_r <= eff_pos_s;
          dir_r <= eff_dir_s;
          if (paused_s) begin
            move_en_r <= 1'b0;
          end else if (div_hit_s) begin
            div_r     <= 4'd0;
            move_en_r <= 1'b1;
          end else begin
            div_r     <= div_inc_s;
            move_en_r <= 1'b0;
          end
          state_r <= S_STEP;
        end
        S_STEP: begin
          pos_r         <= new_pos_s;
          dir_r         <= new_dir_s;
          bar_lo_r      <= new_pos_s;
          bar_hi_r      <= bar_end(new_pos_s, width_r);
          bar_dir_r     <= new_dir_s;
          update_done_r <= 1'b1;
          state_r       <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign cfg_ready   = cfg_ready_r;
  assign bar_lo      = bar_lo_r;
  assign bar_hi      = bar_hi_r;
  assign bar_dir     = bar_dir_r;
  assign update_done = update_done_r;
  assign overrun     = overrun_r;

endmodule

// File: tb/tb_bar_motion_ctrl.sv
// Directed bench for bar_motion_ctrl: table of config/frame steps plus hand-written handshake,
// overrun, reset-abort and frame-divider sequences. A second instance runs with FRAME_DIV=4.
module tb_bar_motion_ctrl;

  logic       clk;
  logic       rst_n;
  logic       frame_start;
  logic       cfg_valid;
  logic [3:0] cfg_step;
  logic [5:0] cfg_width;
  logic       cfg_bounce;
  logic       cfg_ready;
  logic [9:0] bar_lo;
  logic [9:0] bar_hi;
  logic       bar_dir;
  logic       update_done;
  logic       overrun;
  logic       cfg_ready4;
  logic [9:0] bar_lo4;
  logic [9:0] bar_hi4;
  logic       bar_dir4;
  logic       update_done4;
  logic       overrun4;
`ifdef BAR_MOTION_PAUSE_EN
  logic       pause;
  initial pause = 1'b0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  bar_motion_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .cfg_valid(cfg_valid),
    .cfg_step(cfg_step), .cfg_width(cfg_width), .cfg_bounce(cfg_bounce),
`ifdef BAR_MOTION_PAUSE_EN
    .pause(pause),
`endif
    .cfg_ready(cfg_ready), .bar_lo(bar_lo), .bar_hi(bar_hi), .bar_dir(bar_dir),
    .update_done(update_done), .overrun(overrun)
  );

  bar_motion_ctrl #(.FRAME_DIV(4)) u_div4 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .cfg_valid(cfg_valid),
    .cfg_step(cfg_step), .cfg_width(cfg_width), .cfg_bounce(cfg_bounce),
`ifdef BAR_MOTION_PAUSE_EN
    .pause(pause),
`endif
    .cfg_ready(cfg_ready4), .bar_lo(bar_lo4), .bar_hi(bar_hi4), .bar_dir(bar_dir4),
    .update_done(update_done4), .overrun(overrun4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    bit         cfg;
    logic [3:0] step;
    logic [5:0] width;
    bit         bounce;
    int         frames;
    int         lo;
    int         hi;
    bit         dir;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic do_cfg(input logic [3:0] st, input logic [5:0] wd, input bit bn);
    int n;
    n = 0;
    while (!cfg_ready && n < 20) begin
      tick();
      n++;
    end
    chk("cfg_ready_wait", int'(cfg_ready), 1);
    cfg_valid  = 1'b1;
    cfg_step   = st;
    cfg_width  = wd;
    cfg_bounce = bn;
    tick();
    cfg_valid = 1'b0;
    chk("cfg_accept_ready_low", int'(cfg_ready), 0);
  endtask

  // One frame: update_done must be low after edges k and k+1 and high after k+2.
  task automatic run_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("upd_after_k", int'(update_done), 0);
    tick();
    chk("upd_after_k1", int'(update_done), 0);
    tick();
    chk("upd_after_k2", int'(update_done), 1);
    chk("upd4_after_k2", int'(update_done4), 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_lo"}, int'(bar_lo), 0);
    chk({tag, "_hi"}, int'(bar_hi), 20);
    chk({tag, "_dir"}, int'(bar_dir), 1);
    chk({tag, "_ready"}, int'(cfg_ready), 1);
    chk({tag, "_upd"}, int'(update_done), 0);
    chk({tag, "_ovr"}, int'(overrun), 0);
  endtask

  initial begin
    //            rst   cfg   step   width  bnc   frames lo   hi   dir
    vecs[0]  = '{1'b1, 1'b0, 4'd0,  6'd0,  1'b0, 1,     1,   21,  1'b1};
    vecs[1]  = '{1'b0, 1'b0, 4'd0,  6'd0,  1'b0, 1,     2,   22,  1'b1};
    vecs[2]  = '{1'b0, 1'b0, 4'd0,  6'd0,  1'b0, 1,     3,   23,  1'b1};
    vecs[3]  = '{1'b1, 1'b1, 4'd7,  6'd20, 1'b0, 90,    630, 640, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 4'd0,  6'd0,  1'b0, 1,     637, 640, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 4'd0,  6'd0,  1'b0, 1,     4,   24,  1'b1};
    vecs[6]  = '{1'b0, 1'b1, 4'd8,  6'd20, 1'b1, 76,    612, 632, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 4'd0,  6'd0,  1'b0, 1,     620, 640, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 4'd0,  6'd0,  1'b0, 1,     612, 632, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 4'd0,  6'd0,  1'b0, 75,    12,  32,  1'b0};
    vecs[10] = '{1'b0, 1'b1, 4'd7,  6'd20, 1'b1, 1,     5,   25,  1'b0};
    vecs[11] = '{1'b0, 1'b1, 4'd8,  6'd20, 1'b1, 1,     0,   20,  1'b1};
    vecs[12] = '{1'b0, 1'b1, 4'd0,  6'd0,  1'b1, 2,     0,   1,   1'b1};
    vecs[13] = '{1'b0, 1'b1, 4'd3,  6'd63, 1'b0, 1,     3,   66,  1'b1};
    vecs[14] = '{1'b1, 1'b1, 4'd10, 6'd20, 1'b0, 60,    600, 620, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 4'd10, 6'd63, 1'b1, 1,     577, 640, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 4'd10, 6'd20, 1'b0, 1,     587, 607, 1'b1};

    rst_n       = 1'b0;
    frame_start = 1'b0;
    cfg_valid   = 1'b0;
    cfg_step    = 4'd0;
    cfg_width   = 6'd0;
    cfg_bounce  = 1'b0;
    tick();
    tick();
    chk_reset_vals("por");
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].rst) do_reset();
      if (vecs[i].cfg) do_cfg(vecs[i].step, vecs[i].width, vecs[i].bounce);
      for (int f = 0; f < vecs[i].frames; f++) run_frame();
      chk($sformatf("vec%0d_lo", i), int'(bar_lo), vecs[i].lo);
      chk($sformatf("vec%0d_hi", i), int'(bar_hi), vecs[i].hi);
      chk($sformatf("vec%0d_dir", i), int'(bar_dir), int'(vecs[i].dir));
    end

    // Handshake: second request held off until the first leaves APPLY.
    do_reset();
    cfg_valid  = 1'b1;
    cfg_step   = 4'd2;
    cfg_width  = 6'd10;
    cfg_bounce = 1'b0;
    tick();
    chk("hs_first_accept", int'(cfg_ready), 0);
    cfg_step  = 4'd3;
    cfg_width = 6'd0;
    tick();
    tick();
    chk("hs_held_off", int'(cfg_ready), 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("hs_ready_in_apply", int'(cfg_ready), 0);
    tick();
    chk("hs_ready_after_apply", int'(cfg_ready), 1);
    tick();
    cfg_valid = 1'b0;
    chk("hs_second_accept", int'(cfg_ready), 0);
    chk("hs_upd", int'(update_done), 1);
    chk("hs_lo_first_cfg", int'(bar_lo), 2);
    chk("hs_hi_first_cfg", int'(bar_hi), 12);
    run_frame();
    chk("hs_lo_second_cfg", int'(bar_lo), 5);
    chk("hs_hi_width0", int'(bar_hi), 6);
    chk("hs_ready_back", int'(cfg_ready), 1);

    // Overrun: frame_start held into APPLY.
    chk("ovr_clear", int'(overrun), 0);
    frame_start = 1'b1;
    tick();
    tick();
    frame_start = 1'b0;
    chk("ovr_set", int'(overrun), 1);
    chk("ovr_upd_not_yet", int'(update_done), 0);
    tick();
    chk("ovr_upd", int'(update_done), 1);
    chk("ovr_lo", int'(bar_lo), 8);
    run_frame();
    chk("ovr_lo_next", int'(bar_lo), 11);
    chk("ovr_sticky", int'(overrun), 1);

    // Reset during STEP with a config pending.
    do_reset();
    chk("rst_ovr_cleared", int'(overrun), 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    cfg_valid   = 1'b1;
    cfg_step    = 4'd9;
    cfg_width   = 6'd40;
    cfg_bounce  = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("mid_pending", int'(cfg_ready), 0);
    rst_n = 1'b0;
    tick();
    chk_reset_vals("mid_rst");
    rst_n = 1'b1;
    run_frame();
    chk("mid_lo1", int'(bar_lo), 1);
    chk("mid_hi1", int'(bar_hi), 21);
    chk("mid_dir1", int'(bar_dir), 1);
    run_frame();
    chk("mid_lo2", int'(bar_lo), 2);
    chk("mid_hi2", int'(bar_hi), 22);

    // FRAME_DIV=4: moves on every fourth frame only.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      run_frame();
      chk($sformatf("div4_lo_f%0d", i), int'(bar_lo4), i / 4);
      chk($sformatf("div1_lo_f%0d", i), int'(bar_lo), i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
